// File: rtl/div_unit.sv
// div_unit -- iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit is produced per cycle in CALC, followed by one sign fix-up
// cycle (FIX) and a one-cycle result pulse (DONE).
//
// Optional feature macro: DIV_EARLY_OUT_EN
//   When defined, divide-by-zero and signed overflow bypass CALC/FIX. The
//   special result is written at the accept edge and the FSM goes straight
//   to DONE. When undefined, every operation takes the full iterative path.
//   Results are identical in both builds.
//
// Ports:
//   clk        in   1     clock, rising edge
//   rst        in   1     asynchronous active-high reset
//   start      in   1     request; accepted when start & in_ready & divide opcode
//   operation  in   5     ALU opcode (DIV/DIVU/REM/REMU)
//   opa        in   XLEN  dividend
//   opb        in   XLEN  divisor
//   flush      in   1     synchronous kill of any in-flight operation
//   in_ready   out  1     high only in IDLE
//   busy       out  1     high in CALC/FIX/DONE
//   out_valid  out  1     one-cycle pulse in DONE
//   result     out  XLEN  quotient or remainder of the latched operation
module div_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [4:0]      operation,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  input  logic            flush,
  output logic            in_ready,
  output logic            busy,
  output logic            out_valid,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN + 1);

  // Opcode encodings shared with the ALU decode.
  localparam logic [4:0] ALU_DIV  = 5'h0E;
  localparam logic [4:0] ALU_DIVU = 5'h0F;
  localparam logic [4:0] ALU_REM  = 5'h10;
  localparam logic [4:0] ALU_REMU = 5'h11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN:0]   rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            is_rem_q, is_rem_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;

  // Request decode
  logic            is_div_op;
  logic            op_signed;
  logic            op_rem;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            accept;

  // Iteration datapath
  logic [XLEN+1:0] shifted;
  logic [XLEN+1:0] diff;
  logic            ge;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;

`ifdef DIV_EARLY_OUT_EN
  logic            div_zero;
  logic            sgn_ovf;
  logic [XLEN-1:0] special_res;
`endif

  always_comb begin
    is_div_op = (operation == ALU_DIV)  || (operation == ALU_DIVU) ||
                (operation == ALU_REM)  || (operation == ALU_REMU);
    op_signed = (operation == ALU_DIV)  || (operation == ALU_REM);
    op_rem    = (operation == ALU_REM)  || (operation == ALU_REMU);
    a_neg     = op_signed & opa[XLEN-1];
    b_neg     = op_signed & opb[XLEN-1];
    a_mag     = a_neg ? -opa : opa;
    b_mag     = b_neg ? -opb : opb;
    accept    = start & (state_q == S_IDLE) & is_div_op & ~flush;

    // Remainder is XLEN+1 bits; one extra guard bit makes the borrow visible.
    shifted   = {rem_q, quo_q[XLEN-1]};
    diff      = shifted - {2'b00, dvs_q};
    ge        = ~diff[XLEN+1];

    quo_fix   = neg_quo_q ? -quo_q : quo_q;
    rem_fix   = neg_rem_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
  end

`ifdef DIV_EARLY_OUT_EN
  always_comb begin
    div_zero    = (opb == '0);
    sgn_ovf     = op_signed & (opa == {1'b1, {(XLEN-1){1'b0}}}) & (opb == '1);
    special_res = div_zero ? (op_rem ? opa : '1) : (op_rem ? '0 : opa);
  end
`endif

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    is_rem_d  = is_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;

    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            rem_d     = '0;
            quo_d     = a_mag;
            dvs_d     = b_mag;
            cnt_d     = CW'(XLEN);
            is_rem_d  = op_rem;
            // A zero divisor yields an all-ones quotient magnitude; leaving it
            // un-negated gives -1 regardless of the dividend sign.
            neg_quo_d = (a_neg ^ b_neg) & (opb != '0);
            neg_rem_d = a_neg;
`ifdef DIV_EARLY_OUT_EN
            if (div_zero || sgn_ovf) begin
              result_d = special_res;
              state_d  = S_DONE;
            end else begin
              state_d  = S_CALC;
            end
`else
            state_d   = S_CALC;
`endif
          end
        end
        S_CALC: begin
          rem_d = ge ? diff[XLEN:0] : shifted[XLEN:0];
          quo_d = {quo_q[XLEN-2:0], ge};
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_d = S_FIX;
          end
        end
        S_FIX: begin
          result_d = is_rem_q ? rem_fix : quo_fix;
          state_d  = S_DONE;
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
      is_rem_q  <= is_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    out_valid = (state_q == S_DONE);
    result    = result_q;
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit -- self-checking bench for div_unit: directed RV32M corner cases,
// flush/reset behaviour, and randomized operations compared with an
// arithmetic reference model. Honours DIV_EARLY_OUT_EN for expected latency.
module tb_div_unit;

  localparam int unsigned XLEN = 32;
  localparam logic [4:0] OP_DIV  = 5'h0E;
  localparam logic [4:0] OP_DIVU = 5'h0F;
  localparam logic [4:0] OP_REM  = 5'h10;
  localparam logic [4:0] OP_REMU = 5'h11;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  operation;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        flush;
  logic        in_ready;
  logic        busy;
  logic        out_valid;
  logic [31:0] result;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  div_unit #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .operation (operation),
    .opa       (opa),
    .opb       (opb),
    .flush     (flush),
    .in_ready  (in_ready),
    .busy      (busy),
    .out_valid (out_valid),
    .result    (result)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // RISC-V M-extension semantics in plain integer arithmetic.
  function automatic logic [31:0] ref_model(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    case (op)
      OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REMU: return (b == 0) ? a : a % b;
      OP_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == INT_MIN && b == 32'hFFFF_FFFF) return a;
        return 32'(sa / sb);
      end
      default: begin
        if (b == 0) return a;
        if (a == INT_MIN && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sa % sb);
      end
    endcase
  endfunction

  // Rising edges from the edge that samples start up to the one that raises out_valid.
  function automatic int unsigned exp_lat(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    bit special;
    special = (b == 0) ||
              ((op == OP_DIV || op == OP_REM) && a == INT_MIN && b == 32'hFFFF_FFFF);
`ifdef DIV_EARLY_OUT_EN
    if (special) return 1;
`else
    if (special) return XLEN + 2;
`endif
    return XLEN + 2;
  endfunction

  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string tag);
    int unsigned edges;
    bit seen;
    bit rdy_bad;
    @(negedge clk);
    start = 1'b1;
    operation = op;
    opa = a;
    opb = b;
    edges = 0;
    seen = 1'b0;
    rdy_bad = 1'b0;
    while (!seen && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
      if (edges == 1) begin
        start = 1'b0;
        opa = $urandom;
        opb = $urandom;
      end
      if (in_ready) rdy_bad = 1'b1;
      if (out_valid) seen = 1'b1;
    end
    check({tag, "/valid"}, 32'(seen), 32'd1);
    check({tag, "/result"}, result, exp);
    check({tag, "/latency"}, edges, exp_lat(op, a, b));
    check({tag, "/ready_low"}, 32'(rdy_bad), 32'd0);
    @(posedge clk);
    #1;
    check({tag, "/pulse"}, 32'(out_valid), 32'd0);
    check({tag, "/ready_back"}, 32'(in_ready), 32'd1);
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$] = '{
    '{OP_DIV,  32'd20,        32'hFFFF_FFFD, 32'hFFFF_FFFA},
    '{OP_REM,  32'd20,        32'hFFFF_FFFD, 32'h0000_0002},
    '{OP_REM,  32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFE},
    '{OP_DIVU, 32'hFFFF_FFFF, 32'd2,         32'h7FFF_FFFF},
    '{OP_REMU, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001},
    '{OP_DIV,  32'd7,         32'd0,         32'hFFFF_FFFF},
    '{OP_REM,  32'd7,         32'd0,         32'h0000_0007},
    '{OP_DIVU, 32'd7,         32'd0,         32'hFFFF_FFFF},
    '{OP_REMU, 32'd7,         32'd0,         32'h0000_0007},
    '{OP_DIV,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF},
    '{OP_REM,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9},
    '{OP_DIV,  INT_MIN,       32'hFFFF_FFFF, 32'h8000_0000},
    '{OP_REM,  INT_MIN,       32'hFFFF_FFFF, 32'h0000_0000}
  };

  initial begin
    logic [31:0] saved;
    logic [31:0] first_res;
    int unsigned pulses;
    int unsigned edges;
    logic [4:0] rop;
    logic [31:0] ra;
    logic [31:0] rb;

    rst = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    operation = 5'h0;
    opa = '0;
    opb = '0;
    #12;
    check("reset/in_ready", 32'(in_ready), 32'd1);
    check("reset/busy", 32'(busy), 32'd0);
    check("reset/out_valid", 32'(out_valid), 32'd0);
    check("reset/result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Non-divide opcode is not accepted.
    @(negedge clk);
    start = 1'b1;
    operation = 5'h00;
    opa = 32'd9;
    opb = 32'd3;
    @(posedge clk);
    #1;
    check("nondiv/in_ready", 32'(in_ready), 32'd1);
    check("nondiv/busy", 32'(busy), 32'd0);
    start = 1'b0;

    foreach (vecs[i]) begin
      check($sformatf("model%0d", i), ref_model(vecs[i].op, vecs[i].a, vecs[i].b), vecs[i].exp);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("dir%0d", i));
    end

    // Flush 10 cycles into DIVU 100,7.
    saved = result;
    @(negedge clk);
    start = 1'b1;
    operation = OP_DIVU;
    opa = 32'd100;
    opb = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush/in_ready", 32'(in_ready), 32'd1);
    check("flush/busy", 32'(busy), 32'd0);
    pulses = 0;
    for (int unsigned i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) pulses++;
    end
    check("flush/no_valid", pulses, 32'd0);
    check("flush/result_kept", result, saved);
    run_op(OP_DIVU, 32'd100, 32'd7, 32'h0000_000E, "after_flush");

    // Flush and start together: flush wins.
    @(negedge clk);
    start = 1'b1;
    flush = 1'b1;
    operation = OP_DIV;
    opa = 32'd50;
    opb = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    check("flush_start/in_ready", 32'(in_ready), 32'd1);
    check("flush_start/busy", 32'(busy), 32'd0);

    // Flush during DONE: out_valid stays visible that cycle.
    @(negedge clk);
    start = 1'b1;
    operation = OP_REMU;
    opa = 32'd50;
    opb = 32'd7;
    edges = 0;
    while (!out_valid && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
      start = 1'b0;
    end
    flush = 1'b1;
    #1;
    check("flush_done/valid", 32'(out_valid), 32'd1);
    check("flush_done/result", result, 32'd1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_done/in_ready", 32'(in_ready), 32'd1);
    check("flush_done/pulse", 32'(out_valid), 32'd0);

    // start held while busy is ignored; operands scrambled after accept.
    @(negedge clk);
    start = 1'b1;
    operation = OP_DIVU;
    opa = 32'd1000;
    opb = 32'd10;
    pulses = 0;
    first_res = '0;
    for (int unsigned i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) begin
        opa = $urandom;
        opb = $urandom;
      end
      if (out_valid) begin
        pulses++;
        if (pulses == 1) first_res = result;
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("held_start/pulses", pulses, 32'd1);
    check("held_start/result", first_res, 32'd100);

    // Asynchronous reset mid-CALC.
    @(negedge clk);
    start = 1'b1;
    operation = OP_DIVU;
    opa = 32'h0000_FFFF;
    opb = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst/busy", 32'(busy), 32'd0);
    check("async_rst/result", result, 32'd0);
    check("async_rst/in_ready", 32'(in_ready), 32'd1);
    check("async_rst/out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Randomized operations against the reference model.
    for (int unsigned i = 0; i < 150; i++) begin
      case ($urandom_range(0, 3))
        0: rop = OP_DIV;
        1: rop = OP_DIVU;
        2: rop = OP_REM;
        default: rop = OP_REMU;
      endcase
      case ($urandom_range(0, 5))
        0: begin ra = $urandom; rb = 32'd0; end
        1: begin ra = INT_MIN; rb = 32'hFFFF_FFFF; end
        2: begin ra = $urandom_range(0, 200); rb = $urandom_range(1, 20); end
        3: begin ra = $urandom; rb = 32'($urandom_range(0, 15)) - 32'd8; end
        default: begin ra = $urandom; rb = $urandom; end
      endcase
      run_op(rop, ra, rb, ref_model(rop, ra, rb), $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
